stall_ctrl: RTL and testbench
=============================

// Module: stall_ctrl
// PURPOSE
//   Pipeline control unit: the producer of the 6-bit stall vector that every pipeline register
//   (pc, if_id, id_ex, ex_mem, mem_wb) samples, plus the exception/ERET flush and redirect PC.
//   Merges stall requests from IF, ID, EX and MEM into one stall vector.
//   Also keeps stall/flush perf counters and a sticky watchdog for pipeline lock-up.
// PARAMETERS
//   EXC_VECTOR   32'h0000_0020  new_pc for every exception except ERET
//   ERET_TYPE    32'h0000_000e  excepttype code meaning ERET (redirect to epc)
//   TIMEOUT      1024           consecutive stalled cycles that set stall_timeout (>=2)
//   CNT_W        32             width of perf counters (wrap modulo 2^CNT_W)
// PORTS
//   clk             in   1      clock; all state updates on posedge
//   rst             in   1      synchronous reset, active-high (`RESET_ENABLE)
//   stallreq_if     in   1      IF waiting on instruction fetch
//   stallreq_id     in   1      ID load-use hazard
//   stallreq_ex     in   1      EX multi-cycle op (div/madd) busy
//   stallreq_mem    in   1      MEM waiting on data bus
//   excepttype      in   32     from MEM; nonzero = exception committing this cycle
//   epc             in   32     CP0 EPC, used for ERET
//   stall           out  6      [0]PC [1]IF [2]ID [3]EX [4]MEM [5]WB; `STOP=1
//   flush           out  1      flush all pipeline registers this cycle
//   new_pc          out  32     redirect target, valid when flush=1, else 0
//   stall_cycles    out  CNT_W  cycles with stall[0]=`STOP since reset
//   flush_count     out  CNT_W  flush events since reset
//   stall_timeout   out  1      sticky: pipeline stalled TIMEOUT consecutive cycles
// BEHAVIOUR
//   - stall/flush/new_pc are combinational from current inputs (same-cycle, registers sample at posedge).
//   - Priority (first match): rst=1 -> all zero; excepttype!=0 -> flush=1, stall=6'b000000,
//     new_pc = (excepttype==ERET_TYPE) ? epc : EXC_VECTOR; stallreq_mem -> 6'b011111;
//     stallreq_ex -> 6'b001111; stallreq_id -> 6'b000111; stallreq_if -> 6'b000011;
//     else 6'b000000, flush=0, new_pc=0.
//   - A stall from stage k holds stages 0..k; stage k+1 receives a bubble from its register
//     (stop below / nostop above). WB (bit5) is never stalled.
//   - Flush overrides all stall requests in the same cycle; stall requests are not remembered.
//   - Sequential state (synchronous reset clears all to 0: counters, run counter, stall_timeout):
//     * stall_cycles += 1 each cycle stall[0]==`STOP; wraps to 0 at 2^CNT_W.
//     * flush_count  += 1 each cycle flush==1 (back-to-back flushes count individually).
//     * run counter: +1 per cycle stall[0]==`STOP, cleared to 0 on any non-stalled cycle or flush;
//       saturates at TIMEOUT; stall_timeout set in the cycle after run counter reaches TIMEOUT
//       (i.e. registered), stays 1 until rst. Does not itself alter stall.
//   - Reset mid-stall: rst cycle outputs stall=0, flush=0; counters are 0 in the following cycle.
//   - Output reset values: stall=0, flush=0, new_pc=0, stall_cycles=0, flush_count=0, stall_timeout=0.
// TESTING
//   1. Hold each stallreq_* alone one cycle -> stall = 000011/000111/001111/011111; stall_cycles +1 each.
//   2. stallreq_id=1 and stallreq_mem=1 together -> stall=6'b011111 (MEM wins).
//   3. stallreq_ex=1 with excepttype=32'h0000_0008 -> flush=1, stall=0, new_pc=32'h0000_0020, flush_count=1.
//   4. excepttype=32'h0000_000e, epc=32'hBFC0_0100 -> flush=1, new_pc=32'hBFC0_0100.
//   5. TIMEOUT=4: stallreq_ex high 4 cycles -> stall_timeout=1 next cycle, stays 1 after req drops;
//      3 stalled, 1 free, 3 stalled -> stall_timeout stays 0.
//   6. rst asserted during stallreq_mem run -> stall=0 that cycle; stall_cycles=0, stall_timeout=0 after.

Source files
------------

// File: rtl/stall_ctrl_if.sv
// Stall/flush control bundle between the pipeline stages and stall_ctrl.
// Latency: none. The interface only groups the signals.
// Backpressure: none. The stall vector itself is the pipeline's backpressure.
interface stall_ctrl_if #(
    parameter int CNT_W = 32
);
    // Requests from the pipeline stages, plus exception info from MEM/CP0
    logic              stallreq_if;
    logic              stallreq_id;
    logic              stallreq_ex;
    logic              stallreq_mem;
    logic [31:0]       excepttype;
    logic [31:0]       epc;

    // Control and status back to the pipeline
    logic [5:0]        stall;
    logic              flush;
    logic [31:0]       new_pc;
    logic [CNT_W-1:0]  stall_cycles;
    logic [CNT_W-1:0]  flush_count;
    logic              stall_timeout;

    // Pipeline side: raises requests and consumes the control outputs
    modport master (
        output stallreq_if, stallreq_id, stallreq_ex, stallreq_mem, excepttype, epc,
        input  stall, flush, new_pc, stall_cycles, flush_count, stall_timeout
    );

    // Controller side
    modport slave (
        input  stallreq_if, stallreq_id, stallreq_ex, stallreq_mem, excepttype, epc,
        output stall, flush, new_pc, stall_cycles, flush_count, stall_timeout
    );
endinterface

// File: rtl/stall_ctrl.sv
// Pipeline control: merges per-stage stall requests into one stall vector and raises an exception/ERET flush.
// Latency: stall/flush/new_pc are same-cycle combinational. The perf counters and the watchdog are registered.
// Backpressure: a stall from stage k holds stages 0..k. WB is never stalled. A flush overrides every stall request.
module stall_ctrl #(
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0020,
    parameter logic [31:0] ERET_TYPE  = 32'h0000_000e,
    parameter int          TIMEOUT    = 1024,
    parameter int          CNT_W      = 32
) (
    input  logic         clk,
    input  logic         rst,
    stall_ctrl_if.slave  bus
);

    localparam logic STOP   = 1'b1;
    localparam int   RUN_W  = $clog2(TIMEOUT + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(TIMEOUT);

    // Each stage's stall pattern: the requesting stage and all older stages hold.
    localparam logic [5:0] STALL_NONE = 6'b000000;
    localparam logic [5:0] STALL_IF   = 6'b000011;
    localparam logic [5:0] STALL_ID   = 6'b000111;
    localparam logic [5:0] STALL_EX   = 6'b001111;
    localparam logic [5:0] STALL_MEM  = 6'b011111;

    logic [5:0]        stall_c;
    logic              flush_c;
    logic [31:0]       new_pc_c;
    logic [CNT_W-1:0]  stall_cycles_q;
    logic [CNT_W-1:0]  flush_count_q;
    logic [RUN_W-1:0]  run_cnt_q;
    logic [RUN_W-1:0]  run_cnt_nxt;
    logic              stall_timeout_q;

    // Priority merge. Reset beats an exception, an exception beats any stall,
    // and a younger stage's request beats an older stage's request.
    always_comb begin
        stall_c  = STALL_NONE;
        flush_c  = 1'b0;
        new_pc_c = 32'h0;
        if (rst) begin
            stall_c  = STALL_NONE;
        end else if (bus.excepttype != 32'h0) begin
            flush_c  = 1'b1;
            new_pc_c = (bus.excepttype == ERET_TYPE) ? bus.epc : EXC_VECTOR;
        end else if (bus.stallreq_mem) begin
            stall_c  = STALL_MEM;
        end else if (bus.stallreq_ex) begin
            stall_c  = STALL_EX;
        end else if (bus.stallreq_id) begin
            stall_c  = STALL_ID;
        end else if (bus.stallreq_if) begin
            stall_c  = STALL_IF;
        end
    end

    // Consecutive-stall run length. It counts only cycles where the PC is held.
    // It saturates so that a very long lock-up cannot wrap around to zero.
    always_comb begin
        run_cnt_nxt = '0;
        if (flush_c || (stall_c[0] != STOP)) begin
            run_cnt_nxt = '0;
        end else if (run_cnt_q == RUN_MAX) begin
            run_cnt_nxt = run_cnt_q;
        end else begin
            run_cnt_nxt = run_cnt_q + RUN_W'(1);
        end
    end

    // Perf counters. They wrap naturally at 2^CNT_W.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            if (stall_c[0] == STOP) begin
                stall_cycles_q <= stall_cycles_q + CNT_W'(1);
            end
            if (flush_c) begin
                flush_count_q <= flush_count_q + CNT_W'(1);
            end
        end
    end

    // Watchdog. It becomes visible in the cycle after the TIMEOUT-th consecutive
    // stalled cycle, and it stays set until reset. It only reports the lock-up
    // and never alters the stall vector.
    always_ff @(posedge clk) begin
        if (rst) begin
            run_cnt_q       <= '0;
            stall_timeout_q <= 1'b0;
        end else begin
            run_cnt_q <= run_cnt_nxt;
            if (run_cnt_nxt == RUN_MAX) begin
                stall_timeout_q <= 1'b1;
            end
        end
    end

    // Drive the interface outputs
    always_comb begin
        bus.stall         = stall_c;
        bus.flush         = flush_c;
        bus.new_pc        = new_pc_c;
        bus.stall_cycles  = stall_cycles_q;
        bus.flush_count   = flush_count_q;
        bus.stall_timeout = stall_timeout_q;
    end

endmodule

// File: tb/tb_stall_ctrl.sv
// Directed bench for stall_ctrl. The driver pushes hand-computed expectations into a queue, and a negedge monitor pops them and checks them.
// Latency: the driver and the monitor both work on the cycle in which the stimulus is applied.
// Backpressure: none. The monitor consumes one queue entry per clock.
module tb_stall_ctrl;

    localparam int TO = 4;

    typedef struct {
        logic [5:0]  stall;
        logic        flush;
        logic [31:0] new_pc;
        logic [31:0] cyc;
        logic [31:0] fcnt;
        logic        tmo;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    stall_ctrl_if #(.CNT_W(32)) bus ();

    stall_ctrl #(
        .EXC_VECTOR (32'h0000_0020),
        .ERET_TYPE  (32'h0000_000e),
        .TIMEOUT    (TO),
        .CNT_W      (32)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    exp_t q[$];
    exp_t e;
    int   n_cmp  = 0;
    int   n_fail = 0;

    // Reference state for the registered outputs, as seen during the current cycle
    logic [31:0] m_cyc  = 0;
    logic [31:0] m_fcnt = 0;
    int          m_run  = 0;
    logic        m_tmo  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: it checks every output against the oldest pending expectation
    always @(negedge clk) begin
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("stall",         {26'h0, bus.stall},      {26'h0, e.stall});
            chk("flush",         {31'h0, bus.flush},      {31'h0, e.flush});
            chk("new_pc",        bus.new_pc,              e.new_pc);
            chk("stall_cycles",  bus.stall_cycles,        e.cyc);
            chk("flush_count",   bus.flush_count,         e.fcnt);
            chk("stall_timeout", {31'h0, bus.stall_timeout}, {31'h0, e.tmo});
        end
    end

    // Drive one cycle. req = {mem, ex, id, if}. es/ef/ep are the hand-computed stall, flush and new_pc.
    task automatic apply(input logic r, input logic [3:0] req, input logic [31:0] exc,
                         input logic [31:0] e_pc, input logic [5:0] es, input logic ef,
                         input logic [31:0] ep);
        exp_t x;
        rst              = r;
        bus.stallreq_if  = req[0];
        bus.stallreq_id  = req[1];
        bus.stallreq_ex  = req[2];
        bus.stallreq_mem = req[3];
        bus.excepttype   = exc;
        bus.epc          = e_pc;
        x.stall  = es;
        x.flush  = ef;
        x.new_pc = ep;
        x.cyc    = m_cyc;
        x.fcnt   = m_fcnt;
        x.tmo    = m_tmo;
        q.push_back(x);
        @(posedge clk);
        if (r) begin
            m_cyc = 0; m_fcnt = 0; m_run = 0; m_tmo = 0;
        end else begin
            if (es[0]) m_cyc = m_cyc + 1;
            if (ef)    m_fcnt = m_fcnt + 1;
            if (es[0] && !ef) m_run = (m_run == TO) ? TO : m_run + 1;
            else              m_run = 0;
            if (m_run == TO) m_tmo = 1'b1;
        end
        #1;
    endtask

    task automatic idle();
        apply(1'b0, 4'b0000, 32'h0, 32'h0, 6'b000000, 1'b0, 32'h0);
    endtask

    initial begin
        bus.stallreq_if  = 1'b0;
        bus.stallreq_id  = 1'b0;
        bus.stallreq_ex  = 1'b0;
        bus.stallreq_mem = 1'b0;
        bus.excepttype   = 32'h0;
        bus.epc          = 32'h0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state, with a stall request present that must be ignored
        apply(1'b1, 4'b1111, 32'h0, 32'h0, 6'b000000, 1'b0, 32'h0);
        idle();

        // Each request on its own
        apply(1'b0, 4'b0001, 32'h0, 32'h0, 6'b000011, 1'b0, 32'h0); idle();
        apply(1'b0, 4'b0010, 32'h0, 32'h0, 6'b000111, 1'b0, 32'h0); idle();
        apply(1'b0, 4'b0100, 32'h0, 32'h0, 6'b001111, 1'b0, 32'h0); idle();
        apply(1'b0, 4'b1000, 32'h0, 32'h0, 6'b011111, 1'b0, 32'h0); idle();

        // ID and MEM together: MEM wins
        apply(1'b0, 4'b1010, 32'h0, 32'h0, 6'b011111, 1'b0, 32'h0); idle();

        // An exception overrides EX busy
        apply(1'b0, 4'b0100, 32'h0000_0008, 32'h0, 6'b000000, 1'b1, 32'h0000_0020);
        // ERET redirects to epc
        apply(1'b0, 4'b0000, 32'h0000_000e, 32'hBFC0_0100, 6'b000000, 1'b1, 32'hBFC0_0100);
        // ERET with every stall request raised, back to back with the previous flush
        apply(1'b0, 4'b1111, 32'h0000_000e, 32'h1234_5678, 6'b000000, 1'b1, 32'h1234_5678);
        apply(1'b0, 4'b0000, 32'h0000_0004, 32'hDEAD_BEEF, 6'b000000, 1'b1, 32'h0000_0020);
        idle();

        // Three stalled cycles, one free cycle, three stalled cycles: the watchdog must not fire
        repeat (3) apply(1'b0, 4'b0100, 32'h0, 32'h0, 6'b001111, 1'b0, 32'h0);
        idle();
        repeat (3) apply(1'b0, 4'b0001, 32'h0, 32'h0, 6'b000011, 1'b0, 32'h0);
        idle();

        // A stall interrupted by a flush also restarts the run
        repeat (3) apply(1'b0, 4'b0100, 32'h0, 32'h0, 6'b001111, 1'b0, 32'h0);
        apply(1'b0, 4'b0100, 32'h0000_0008, 32'h0, 6'b000000, 1'b1, 32'h0000_0020);
        apply(1'b0, 4'b0100, 32'h0, 32'h0, 6'b001111, 1'b0, 32'h0);
        idle();

        // Four stalled cycles: the watchdog sets the next cycle and stays set
        repeat (4) apply(1'b0, 4'b0100, 32'h0, 32'h0, 6'b001111, 1'b0, 32'h0);
        idle();
        idle();
        apply(1'b0, 4'b0010, 32'h0, 32'h0, 6'b000111, 1'b0, 32'h0);

        // Reset during a MEM stall run
        repeat (2) apply(1'b0, 4'b1000, 32'h0, 32'h0, 6'b011111, 1'b0, 32'h0);
        apply(1'b1, 4'b1000, 32'h0, 32'h0, 6'b000000, 1'b0, 32'h0);
        apply(1'b0, 4'b1000, 32'h0, 32'h0, 6'b011111, 1'b0, 32'h0);
        idle();

        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        if (q.size() > 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, required 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
